// File: rtl/ts_rx_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : ts_rx_analyzer
// Brief    : Per-lane TS1/TS2 receive analyzer. Classifies training sets,
//            counts identical consecutive sets and reports hits and fields.
// Revision : 1.0 - initial release
// ============================================================================
module ts_rx_analyzer #(
    parameter int CNT_TARGET = 8,
    parameter int CNT_W      = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ts_i,
    input  logic         ts_i_vld,
    input  logic         tsa_clr,
    output logic         ts1_hit,
    output logic         ts2_hit,
    output logic         rx_ts_vld,
    output logic [7:0]   rx_link_num,
    output logic [7:0]   rx_lane_num,
    output logic [7:0]   rx_n_fts,
    output logic [7:0]   rx_rate,
    output logic [7:0]   rx_ctrl,
    output logic         link_pad,
    output logic         lane_pad,
    output logic         rx_active,
    output logic [7:0]   bad_ts_cnt
);

    localparam logic [1:0]       c_type_none  = 2'd0;
    localparam logic [1:0]       c_type_ts1   = 2'd1;
    localparam logic [1:0]       c_type_ts2   = 2'd2;
    localparam logic [7:0]       c_com        = 8'hBC;
    localparam logic [7:0]       c_ts1_id     = 8'h4A;
    localparam logic [7:0]       c_ts2_id     = 8'h45;
    localparam logic [7:0]       c_pad        = 8'hF7;
    localparam logic [CNT_W-1:0] c_cnt_target = CNT_W'(CNT_TARGET);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [15:0]      c_timeout    = 16'(TIMEOUT);

    logic [127:0]     r_s1_ts;
    logic             r_s1_vld;
    logic [1:0]       r_type;
    logic [CNT_W-1:0] r_cnt;
    logic [39:0]      r_fields;
    logic             r_ts1_hit;
    logic             r_ts2_hit;
    logic             r_rx_ts_vld;
    logic             r_rx_active;
    logic [7:0]       r_bad_cnt;
    logic [15:0]      r_to_cnt;

    logic [15:6]      w_is_4a;
    logic [15:6]      w_is_45;
    logic             w_com;
    logic             w_is_ts1;
    logic             w_is_ts2;
    logic             w_good;
    logic [1:0]       w_type;
    logic [39:0]      w_syms;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_to_expire;

    genvar k;
    generate
        for (k = 6; k < 16; k++) begin : g_sym_id
            assign w_is_4a[k] = (r_s1_ts[8*k +: 8] == c_ts1_id);
            assign w_is_45[k] = (r_s1_ts[8*k +: 8] == c_ts2_id);
        end
    endgenerate

    assign w_com    = (r_s1_ts[7:0] == c_com);
    assign w_is_ts1 = w_com && (&w_is_4a);
    assign w_is_ts2 = w_com && (&w_is_45);
    assign w_good   = w_is_ts1 || w_is_ts2;
    assign w_type   = w_is_ts1 ? c_type_ts1 : (w_is_ts2 ? c_type_ts2 : c_type_none);
    assign w_syms   = r_s1_ts[47:8];

    // Previous symbols are exactly the retained fields; a cleared type blocks the match.
    assign w_match    = (r_type != c_type_none) && (w_type == r_type) && (w_syms == r_fields);
    assign w_cnt_inc  = (r_cnt >= c_cnt_target) ? c_cnt_target : r_cnt + c_cnt_one;
    assign w_cnt_next = w_match ? w_cnt_inc : c_cnt_one;

    // Fires on the cycle the idle counter reaches TIMEOUT and stays asserted while saturated.
    assign w_to_expire = !ts_i_vld && (r_to_cnt >= c_timeout - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_ts     <= '0;
            r_s1_vld    <= 1'b0;
            r_type      <= c_type_none;
            r_cnt       <= '0;
            r_fields    <= '0;
            r_ts1_hit   <= 1'b0;
            r_ts2_hit   <= 1'b0;
            r_rx_ts_vld <= 1'b0;
            r_rx_active <= 1'b0;
            r_bad_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_rx_ts_vld <= 1'b0;

            if (ts_i_vld) begin
                r_to_cnt <= '0;
            end else if (w_to_expire) begin
                r_to_cnt <= c_timeout;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if (tsa_clr) begin
                r_s1_vld  <= 1'b0;
                r_type    <= c_type_none;
                r_cnt     <= '0;
                r_ts1_hit <= 1'b0;
                r_ts2_hit <= 1'b0;
                r_bad_cnt <= '0;
            end else begin
                r_s1_vld <= ts_i_vld;
                if (ts_i_vld) begin
                    r_s1_ts <= ts_i;
                end
                if (r_s1_vld) begin
                    if (w_good) begin
                        r_cnt       <= w_cnt_next;
                        r_type      <= w_type;
                        r_fields    <= w_syms;
                        r_rx_ts_vld <= 1'b1;
                        r_rx_active <= 1'b1;
                        r_ts1_hit   <= (w_cnt_next == c_cnt_target) && w_is_ts1;
                        r_ts2_hit   <= (w_cnt_next == c_cnt_target) && w_is_ts2;
                    end else begin
                        r_cnt     <= '0;
                        r_type    <= c_type_none;
                        r_ts1_hit <= 1'b0;
                        r_ts2_hit <= 1'b0;
                        if (r_bad_cnt != 8'hFF) begin
                            r_bad_cnt <= r_bad_cnt + 8'd1;
                        end
                    end
                end
            end

            if (w_to_expire) begin
                r_rx_active <= 1'b0;
                r_cnt       <= '0;
                r_ts1_hit   <= 1'b0;
                r_ts2_hit   <= 1'b0;
            end
        end
    end

    assign ts1_hit     = r_ts1_hit;
    assign ts2_hit     = r_ts2_hit;
    assign rx_ts_vld   = r_rx_ts_vld;
    assign rx_link_num = r_fields[7:0];
    assign rx_lane_num = r_fields[15:8];
    assign rx_n_fts    = r_fields[23:16];
    assign rx_rate     = r_fields[31:24];
    assign rx_ctrl     = r_fields[39:32];
    assign link_pad    = (r_fields[7:0] == c_pad);
    assign lane_pad    = (r_fields[15:8] == c_pad);
    assign rx_active   = r_rx_active;
    assign bad_ts_cnt  = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ts_rx_analyzer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ts_rx_analyzer
// Brief    : Self-checking bench for ts_rx_analyzer with a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_rx_analyzer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ts_i;
    logic         ts_i_vld;
    logic         tsa_clr;
    logic         ts1_hit, ts2_hit, rx_ts_vld;
    logic [7:0]   rx_link_num, rx_lane_num, rx_n_fts, rx_rate, rx_ctrl;
    logic         link_pad, lane_pad, rx_active;
    logic [7:0]   bad_ts_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
        logic       h1;
        logic       h2;
    } exp_t;

    exp_t q[$];

    always #0.5 clk = ~clk;

    ts_rx_analyzer #(.CNT_TARGET(8), .CNT_W(4), .TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .ts_i(ts_i), .ts_i_vld(ts_i_vld), .tsa_clr(tsa_clr),
        .ts1_hit(ts1_hit), .ts2_hit(ts2_hit), .rx_ts_vld(rx_ts_vld),
        .rx_link_num(rx_link_num), .rx_lane_num(rx_lane_num), .rx_n_fts(rx_n_fts),
        .rx_rate(rx_rate), .rx_ctrl(rx_ctrl), .link_pad(link_pad), .lane_pad(lane_pad),
        .rx_active(rx_active), .bad_ts_cnt(bad_ts_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_ts(input logic [1:0] typ, input logic [7:0] link,
                                          input logic [7:0] lane, input logic [7:0] nfts,
                                          input logic [7:0] rate, input logic [7:0] ctrl,
                                          input bit corrupt);
        logic [127:0] t;
        t[7:0]   = 8'hBC;
        t[15:8]  = link;
        t[23:16] = lane;
        t[31:24] = nfts;
        t[39:32] = rate;
        t[47:40] = ctrl;
        for (int s = 6; s < 16; s++) t[8*s +: 8] = (typ == 2'd1) ? 8'h4A : 8'h45;
        if (corrupt) t[79:72] = 8'h00;
        return t;
    endfunction

    // Issues one TS at a negedge; good sets push their expected decode and hit levels.
    task automatic send(input logic [1:0] typ, input logic [7:0] link, input logic [7:0] lane,
                        input logic [7:0] rate, input bit bad, input bit e1, input bit e2,
                        input int gap);
        exp_t e;
        @(negedge clk);
        ts_i     = mk_ts(typ, link, lane, 8'h10, rate, 8'h00, bad);
        ts_i_vld = 1'b1;
        if (!bad) begin
            e = '{link: link, lane: lane, nfts: 8'h10, rate: rate, ctrl: 8'h00, h1: e1, h2: e2};
            q.push_back(e);
        end
        @(negedge clk);
        ts_i_vld = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        check(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rx_ts_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_ts_vld: got 1, want 0");
            end else begin
                e = q.pop_front();
                check("rx_link_num", rx_link_num, e.link);
                check("rx_lane_num", rx_lane_num, e.lane);
                check("rx_n_fts", rx_n_fts, e.nfts);
                check("rx_rate", rx_rate, e.rate);
                check("rx_ctrl", rx_ctrl, e.ctrl);
                check("ts1_hit_on_vld", ts1_hit, e.h1);
                check("ts2_hit_on_vld", ts2_hit, e.h2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ts_i = '0; ts_i_vld = 1'b0; tsa_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {ts1_hit, ts2_hit, rx_ts_vld, link_pad, lane_pad, rx_active}, 0);
        check("rst_fields", {rx_link_num, rx_lane_num, rx_n_fts, rx_rate}, 0);
        check("rst_ctrl_bad", {rx_ctrl, bad_ts_cnt}, 0);
        rst = 1'b0;

        // T1: eight identical PAD/PAD TS1s, hit on the eighth
        for (int i = 0; i < 8; i++) send(2'd1, 8'hF7, 8'hF7, 8'h02, 0, (i == 7), 0, 64);
        check_drained("t1_drained");
        check("t1_pads", {link_pad, lane_pad}, 2'b11);
        check("t1_hit", ts1_hit, 1);

        // T2: five TS1 then eight TS2 with link 0
        for (int i = 0; i < 5; i++) send(2'd1, 8'h00, 8'h00, 8'h02, 0, 0, 0, 4);
        for (int i = 0; i < 8; i++) send(2'd2, 8'h00, 8'h00, 8'h02, 0, 0, (i == 7), 4);
        check_drained("t2_drained");
        check("t2_link_pad", link_pad, 0);
        check("t2_ts2_hit", ts2_hit, 1);

        // T3: a corrupted set restarts the run
        for (int i = 0; i < 7; i++) send(2'd1, 8'h01, 8'h00, 8'h02, 0, 0, 0, 4);
        send(2'd1, 8'h01, 8'h00, 8'h02, 1, 0, 0, 4);
        check("t3_bad_cnt", bad_ts_cnt, 1);
        check("t3_no_hit_after_bad", {ts1_hit, ts2_hit}, 0);
        for (int i = 0; i < 8; i++) send(2'd1, 8'h01, 8'h00, 8'h02, 0, (i == 7), 0, 4);
        check_drained("t3_drained");
        check("t3_bad_cnt_end", bad_ts_cnt, 1);

        // T4: idle past TIMEOUT
        repeat (200) @(negedge clk);
        check("t4_active_before", rx_active, 1);
        repeat (60) @(negedge clk);
        check("t4_active_after", rx_active, 0);
        check("t4_hit_after", ts1_hit, 0);
        check("t4_lane_retained", {rx_link_num, rx_lane_num}, 16'h0100);

        // T5: tsa_clr alongside an incoming TS
        for (int i = 0; i < 8; i++) send(2'd1, 8'h01, 8'h00, 8'h02, 0, (i == 7), 0, 4);
        check_drained("t5_pre_drained");
        @(negedge clk);
        ts_i = mk_ts(2'd1, 8'h01, 8'h00, 8'h10, 8'h02, 8'h00, 0);
        ts_i_vld = 1'b1;
        tsa_clr  = 1'b1;
        @(negedge clk);
        ts_i_vld = 1'b0;
        tsa_clr  = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_hit_cleared", ts1_hit, 0);
        check("t5_bad_cleared", bad_ts_cnt, 0);
        check("t5_active_kept", rx_active, 1);
        check("t5_link_kept", rx_link_num, 8'h01);
        for (int i = 0; i < 9; i++) send(2'd1, 8'h01, 8'h00, 8'h02, 0, (i >= 7), 0, 4);
        check_drained("t5_drained");

        // T6: alternating lane numbers never build a run
        for (int i = 0; i < 8; i++) send(2'd1, 8'h01, (i % 2 == 0) ? 8'h01 : 8'h00, 8'h02, 0, 0, 0, 4);
        check_drained("t6_drained");
        check("t6_no_hit", ts1_hit, 0);
        @(negedge clk);
        ts_i = mk_ts(2'd1, 8'h01, 8'h00, 8'h10, 8'h02, 8'h00, 0);
        ts_i_vld = 1'b1;
        @(negedge clk);
        ts_i_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_outputs", {ts1_hit, ts2_hit, rx_ts_vld, link_pad, lane_pad, rx_active}, 0);
        check("t6_rst_fields", {rx_link_num, rx_lane_num, rx_n_fts, rx_rate}, 0);
        check("t6_rst_ctrl_bad", {rx_ctrl, bad_ts_cnt}, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(2'd1, 8'h01, 8'h00, 8'h02, 0, (i == 7), 0, 4);
        check_drained("t6_post_rst_drained");
        check("t6_post_rst_hit", ts1_hit, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
